// File: rtl/rr_mux_pkg.sv
// Shared definitions for the four-channel round-robin packet multiplexer.
//   NUM_CH / PTR_W : channel count and channel-index width
//   state_t        : packet framing state (ARB = no packet open, LOCK = packet open)
//   grant_t        : result of a cyclic priority search (found flag + index)
//   next_grant()   : first valid channel searching cyclically from ptr+1
package rr_mux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned PTR_W  = 2;

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } grant_t;

    // ptr is the most recent winner, so it has the lowest priority (k=NUM_CH wraps to ptr).
    function automatic grant_t next_grant(input logic [PTR_W-1:0] ptr,
                                          input logic [NUM_CH-1:0] valid);
        grant_t           g;
        logic [PTR_W-1:0] c;
        g = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            c = ptr + PTR_W'(k);
            if (!g.found && valid[c]) begin
                g.found = 1'b1;
                g.idx   = c;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_mux_4x1_if.sv
// Handshake bundle between four upstream channels, the multiplexer and one downstream sink.
//   in_valid/in_data/in_last/in_ready : per-channel input streams (channel i at bits [i*WIDTH +: WIDTH])
//   out_valid/out_data/out_ch/out_last/out_ready : merged, channel-tagged output stream
// Modports: slave = the multiplexer, master = the environment driving it.
interface rr_mux_4x1_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_ch;
    logic               out_last;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Combinational cyclic priority picker for four requesters.
//   req        : request bits, one per channel
//   ptr        : last winner; search starts at ptr+1
//   gnt_onehot : one-hot grant (zero when nothing requests)
//   gnt_idx    : index of the granted channel (don't-care when any=0)
//   any        : at least one request present
module rr_arbiter_4
    import rr_mux_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);
    grant_t g;

    assign g = next_grant(ptr, req);

    always_comb begin
        gnt_onehot = '0;
        if (g.found) begin
            gnt_onehot[g.idx] = 1'b1;
        end
        gnt_idx = g.idx;
        any     = g.found;
    end
endmodule

// File: rtl/rr_mux_4x1.sv
// Four-channel round-robin packet multiplexer with a single registered output stage.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_mux_4x1_if slave port carrying the four input streams and the output stream
// A channel that wins arbitration with a non-last beat holds the output until its last
// beat; single-beat packets re-arbitrate every cycle. One beat per cycle sustained.
module rr_mux_4x1
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_4x1_if.slave  bus
);
    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] lock_ch;

    logic [3:0]       gnt_onehot;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;

    logic             load_en;
    logic [3:0]       rdy;
    logic             capture;
    logic [PTR_W-1:0] sel;
    logic [WIDTH-1:0] ch_data [NUM_CH];

    logic             ov;
    logic [WIDTH-1:0] od;
    logic [PTR_W-1:0] och;
    logic             ol;

    rr_arbiter_4 u_arb (
        .req        (bus.in_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // The output register can take a beat when empty or being drained this cycle.
    assign load_en = !ov || bus.out_ready;

    always_comb begin
        rdy = '0;
        if (state == ARB) begin
            if (load_en && gnt_any) begin
                rdy = gnt_onehot;
            end
        end else begin
            rdy[lock_ch] = load_en;
        end
    end

    assign sel     = (state == LOCK) ? lock_ch : gnt_idx;
    assign capture = |(bus.in_valid & rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            ptr     <= PTR_W'(NUM_CH - 1);
            lock_ch <= '0;
            ov      <= 1'b0;
            od      <= '0;
            och     <= '0;
            ol      <= 1'b0;
        end else if (capture) begin
            ov  <= 1'b1;
            od  <= ch_data[sel];
            och <= sel;
            ol  <= bus.in_last[sel];
            if (state == ARB) begin
                ptr <= gnt_idx;
                if (!bus.in_last[gnt_idx]) begin
                    state   <= LOCK;
                    lock_ch <= gnt_idx;
                end
            end else if (bus.in_last[lock_ch]) begin
                state <= ARB;
            end
        end else if (bus.out_ready) begin
            ov <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.out_ch    = och;
    assign bus.out_last  = ol;
endmodule

// File: tb/tb_rr_mux_4x1.sv
// Self-checking bench for rr_mux_4x1: directed scenarios with constant expectations plus
// a randomized run compared against a packet-level reference model.
module tb_rr_mux_4x1;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_mux_4x1_if #(.WIDTH(8)) bus ();

    rr_mux_4x1 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: output register contents, last winner and the open packet (-1 = none).
    logic       m_ov;
    logic [7:0] m_od;
    logic [1:0] m_och;
    logic       m_ol;
    int         m_last;
    int         m_open;

    function automatic logic [3:0] model_ready();
        int c;
        if (m_ov && !bus.out_ready) return 4'b0000;
        if (m_open >= 0) return 4'(1 << m_open);
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (bus.in_valid[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] d0, input logic [7:0] d1,
                                         input logic [7:0] d2, input logic [7:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                         input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
    endtask

    // Advance the model with the inputs present this cycle, then step the clock.
    task automatic tick();
        logic [3:0] acc;
        acc = bus.in_valid & model_ready();
        if (rst) begin
            m_ov = 1'b0; m_od = '0; m_och = '0; m_ol = 1'b0; m_last = 3; m_open = -1;
        end else if (acc != 4'b0000) begin
            for (int c = 0; c < 4; c++) begin
                if (acc[c]) begin
                    m_ov  = 1'b1;
                    m_od  = bus.in_data[c*8 +: 8];
                    m_och = 2'(c);
                    m_ol  = bus.in_last[c];
                    if (m_open < 0) begin
                        m_last = c;
                        if (!m_ol) m_open = c;
                    end else if (m_ol) begin
                        m_open = -1;
                    end
                end
            end
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 32'h0, 4'b0000, 1'b1);
            #1;
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000 || bus.out_ch !== 2'd0
                || bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: ov=%b rdy=%b ch=%0d data=%h last=%b want 0/0000/0/00/0",
                         i, bus.out_valid, bus.in_ready, bus.out_ch, bus.out_data, bus.out_last);
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        int cnt [4];
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int j = 0; j <= 8; j++) begin
            if (j < 8)
                drive(4'hF, pack(8'(cnt[0]), 8'(16 + cnt[1]), 8'(32 + cnt[2]), 8'(48 + cnt[3])),
                      4'hF, 1'b1);
            else
                drive(4'h0, 32'h0, 4'h0, 1'b1);
            #1;
            if (j < 8) begin
                total++;
                if (bus.in_ready !== 4'(1 << (j % 4))) begin
                    bad++;
                    $display("FAIL fair_ready beat %0d: got=%b want=%b", j, bus.in_ready, 4'(1 << (j % 4)));
                end
            end
            if (j > 0) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'((j - 1) % 4)
                    || bus.out_data !== 8'(((j - 1) % 4) * 16 + (j - 1) / 4) || bus.out_last !== 1'b1) begin
                    bad++;
                    $display("FAIL fair_out beat %0d: ov=%b ch=%0d data=%h last=%b want 1/%0d/%h/1",
                             j - 1, bus.out_valid, bus.out_ch, bus.out_data, bus.out_last,
                             (j - 1) % 4, ((j - 1) % 4) * 16 + (j - 1) / 4);
                end
            end
            if (j < 8) cnt[j % 4]++;
            tick();
        end
    endtask

    task automatic test_lock();
        logic [3:0] v  [5] = '{4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0000};
        logic [7:0] d2 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00};
        logic [3:0] l  [5] = '{4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0001};
        logic [3:0] er [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
        logic [7:0] ed [5] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h0C};
        logic [1:0] ec [5] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        logic       el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 5; s++) begin
            drive(v[s], pack(8'h0C, 8'h00, d2[s], 8'h00), l[s], 1'b1);
            #1;
            total++;
            if (bus.in_ready !== er[s]) begin
                bad++;
                $display("FAIL lock_ready step %0d: got=%b want=%b", s, bus.in_ready, er[s]);
            end
            if (s > 0) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== ed[s] || bus.out_ch !== ec[s]
                    || bus.out_last !== el[s]) begin
                    bad++;
                    $display("FAIL lock_out step %0d: ov=%b data=%h ch=%0d last=%b want 1/%h/%0d/%b",
                             s, bus.out_valid, bus.out_data, bus.out_ch, bus.out_last, ed[s], ec[s], el[s]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        drive(4'b0010, pack(8'h00, 8'h5A, 8'h00, 8'h00), 4'b1111, 1'b1);
        #1;
        total++;
        if (bus.in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_first_ready: got=%b want=0010", bus.in_ready);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, pack(8'h00, 8'h5B, 8'h00, 8'h00), 4'b1111, i == 3);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.out_ch !== 2'd1) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: ov=%b data=%h ch=%0d want 1/5a/1",
                         i, bus.out_valid, bus.out_data, bus.out_ch);
            end
            total++;
            if (bus.in_ready !== ((i == 3) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL bp_ready cycle %0d: got=%b want=%b",
                         i, bus.in_ready, (i == 3) ? 4'b0010 : 4'b0000);
            end
            tick();
        end
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5B || bus.out_ch !== 2'd1) begin
            bad++;
            $display("FAIL bp_next: ov=%b data=%h ch=%0d want 1/5b/1", bus.out_valid, bus.out_data, bus.out_ch);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 2; b++) begin
            drive(4'b1000, pack(8'h00, 8'h00, 8'h00, 8'(8'h30 + b)), 4'b0000, 1'b1);
            #1;
            total++;
            if (bus.in_ready !== 4'b1000) begin
                bad++;
                $display("FAIL rmid_ready beat %0d: got=%b want=1000", b, bus.in_ready);
            end
            tick();
        end
        drive(4'b1000, pack(8'h00, 8'h00, 8'h00, 8'h32), 4'b0000, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'b1001, pack(8'h0D, 8'h00, 8'h00, 8'h32), 4'b0001, 1'b1);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_cleared: ov=%b want 0", bus.out_valid);
        end
        total++;
        if (bus.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rmid_regrant: rdy=%b want 0001", bus.in_ready);
        end
        tick();
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 8'h0D) begin
            bad++;
            $display("FAIL rmid_out: ov=%b ch=%0d data=%h want 1/0/0d", bus.out_valid, bus.out_ch, bus.out_data);
        end
        tick();
    endtask

    task automatic test_single_ch1();
        logic [7:0] prev;
        logic [7:0] cur;
        prev = '0;
        for (int i = 0; i <= 12; i++) begin
            cur = 8'($urandom);
            if (i < 12) drive(4'b0010, pack(8'h00, cur, 8'h00, 8'h00), 4'b0010, 1'b1);
            else        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
            #1;
            if (i < 12) begin
                total++;
                if (bus.in_ready !== 4'b0010) begin
                    bad++;
                    $display("FAIL single_ready cycle %0d: got=%b want=0010", i, bus.in_ready);
                end
            end
            if (i > 0) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_ch !== 2'd1
                    || bus.out_data !== prev) begin
                    bad++;
                    $display("FAIL single_out cycle %0d: ov=%b last=%b ch=%0d data=%h want 1/1/1/%h",
                             i, bus.out_valid, bus.out_last, bus.out_ch, bus.out_data, prev);
                end
            end
            prev = cur;
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0] want_rdy;
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3) != 0);
            #1;
            want_rdy = model_ready();
            total++;
            if (bus.in_ready !== want_rdy) begin
                bad++;
                $display("FAIL rand_ready cycle %0d: got=%b want=%b", i, bus.in_ready, want_rdy);
            end
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_ch, bus.out_last} !== {m_ov, m_od, m_och, m_ol}) begin
                bad++;
                $display("FAIL rand_out cycle %0d: ov=%b data=%h ch=%0d last=%b want %b/%h/%0d/%b",
                         i, bus.out_valid, bus.out_data, bus.out_ch, bus.out_last, m_ov, m_od, m_och, m_ol);
            end
            tick();
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        m_ov   = 1'b0;
        m_od   = '0;
        m_och  = '0;
        m_ol   = 1'b0;
        m_last = 3;
        m_open = -1;
        rst    = 1'b1;
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_reset_mid();
        test_single_ch1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_mux_4x1.md
# rr_mux_4x1

Four-channel round-robin packet multiplexer: merges four valid/ready input streams onto one registered output stream, tagging each beat with its source channel. It is the collecting counterpart to the demultiplexer-based fan-out blocks in this codebase. Packets are never interleaved: once a channel wins arbitration, it keeps the output until its last beat. One output register gives a single-cycle latency and a sustained throughput of one beat per cycle.

## Interface
- WIDTH, 8, data bits per beat

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  4  per-channel beat valid; bit i belongs to channel i
- in_data  input  4*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  4  per-channel end-of-packet flag, qualified by in_valid
- in_ready  output  4  per-channel accept; a beat transfers on in_valid[i] & in_ready[i]
- out_valid  output  1  output beat valid
- out_data  output  WIDTH  output beat data
- out_ch  output  2  source channel of the output beat
- out_last  output  1  end-of-packet flag of the output beat
- out_ready  input  1  downstream accept

## Operation
- Clock and reset: one clock (clk). Synchronous active-high reset (rst).
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, state=ARB, ptr=3. With ptr=3, channel 0 has the highest priority for the first grant.
- load_en = !out_valid | out_ready. The output register accepts a new beat only when load_en=1.
- State ARB (no packet open):
  - grant = first i with in_valid[i]=1, searching cyclically from ptr+1 (mod 4).
  - If any channel is valid and load_en=1: in_ready[grant]=1 only; the beat is captured; ptr<=grant.
  - If the captured beat has in_last=0: go to LOCK with lock_ch=grant.
  - If in_last=1: stay in ARB.
- State LOCK:
  - in_ready[lock_ch]=load_en. All other in_ready bits are 0. Other channels' in_valid is ignored.
  - Capturing a beat with in_last=1 returns the block to ARB. ptr already equals lock_ch.
- in_ready is combinational from in_valid, state, ptr, out_valid and out_ready. in_ready never depends on in_data or in_last.
- When out_valid=1 and out_ready=0, out_data, out_ch and out_last stay constant.
- If no beat is captured and out_ready=1, out_valid<=0. The data fields keep their last value.
- A single-beat packet is one beat with in_last=1. It never enters LOCK.
- Reset mid-packet: the open packet is abandoned, output state is cleared and state=ARB. Upstream is responsible for re-framing.

## Timing
- Latency: a beat accepted at edge k appears on the outputs after edge k (out_valid=1 in cycle k+1).
- Throughput: with out_ready held at 1, the block accepts one beat per cycle. There are no bubbles at packet boundaries or on channel switches.
- Simultaneous events: out_ready=1 and a new capture in the same cycle means out_valid stays 1 with new contents.
- Backpressure: out_ready=0 with out_valid=1 forces all in_ready bits to 0 in that same cycle.
- Fairness: with all four channels continuously valid and single-beat packets, the grant order is 0,1,2,3,0,…

## Structure
- Shared package rr_mux_pkg holds:
  - NUM_CH=4 and PTR_W=2
  - the state enum {ARB, LOCK}
  - a function next_grant(ptr, valid) that returns the index and a found flag
- One sub-module is natural: rr_arbiter_4, a combinational cyclic priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_onehot[3:0], gnt_idx[1:0], any.
- The top level holds:
  - the state, ptr and lock_ch registers
  - the output register
  - the in_ready decode

## Test plan
- Reset, then hold in_valid=0 for 5 cycles -> out_valid=0, in_ready=0000, out_ch=0.
- in_valid=1111, all in_last=1, data=ch*16+beat, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no gaps, each beat one cycle after its accept.
- Channel 2 sends a 3-beat packet (A0,A1,A2 with last on A2) while channel 0 stays valid -> out sequence is A0,A1,A2 from channel 2 with no channel-0 beat interleaved, then channel 0 is granted.
- Backpressure: beat 0x5A from channel 1 is on the output, out_ready=0 for 3 cycles -> out_data=0x5A, out_ch=1, out_valid=1 held, in_ready=0000; the next beat appears in the cycle after out_ready=1.
- Assert rst in the middle of a channel-3 packet (beat 2 of 4) -> next cycle out_valid=0 and state=ARB; after release with channels 0 and 3 valid, channel 0 is granted first.
- Single-beat packets only on channel 1, continuous -> in_ready[1]=1 every cycle and one output per cycle, all with out_last=1.
